// File: rtl/pe_scan_if.sv
// Request-vector in / index-stream out bundle for pe_scan.
// The master drives vectors and consumes indices; the slave is the scanner.
interface pe_scan_if #(
  parameter int unsigned WIDTH = 1024,
  parameter int unsigned BW    = $clog2(WIDTH)
);
  logic [WIDTH-1:0] in_vec;
  logic             in_valid;
  logic             in_ready;
  logic             abort;
  logic [BW-1:0]    out_bin;
  logic             out_last;
  logic             out_valid;
  logic             out_ready;
  logic             empty;
  logic             busy;

  modport master (
    output in_vec, in_valid, abort, out_ready,
    input  in_ready, out_bin, out_last, out_valid, empty, busy
  );

  modport slave (
    input  in_vec, in_valid, abort, out_ready,
    output in_ready, out_bin, out_last, out_valid, empty, busy
  );
endinterface

// File: rtl/pe_scan.sv
// Find-and-clear priority encoder: streams the index of every set bit of an
// accepted request vector, one per cycle, lowest- or highest-first.
module pe_scan #(
  parameter int unsigned WIDTH     = 1024,
  parameter int unsigned BW        = $clog2(WIDTH),
  parameter bit          PRIO_HIGH = 1'b0
) (
  input  logic      clk,
  input  logic      rst,
  pe_scan_if.slave  bus
);

  if (BW != $clog2(WIDTH)) begin : gBwCheck
    $error("pe_scan: BW must equal $clog2(WIDTH)");
  end
  if ((WIDTH < 4) || (WIDTH > 4096) || ((WIDTH & (WIDTH - 1)) != 0)) begin : gWidthCheck
    $error("pe_scan: WIDTH must be a power of 2 in 4..4096");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EMIT = 2'd2
  } state_t;

  state_t           state,    stateNxt;
  logic [WIDTH-1:0] mask,     maskNxt;
  logic [BW-1:0]    outBin,   outBinNxt;
  logic             outLast,  outLastNxt;
  logic             outValid, outValidNxt;
  logic             empty,    emptyNxt;

  logic [BW-1:0]    encIdx;
  logic [WIDTH-1:0] clrMask;
  logic             clrLast;

  // Winner index of the remaining mask; last match in loop order wins.
  if (PRIO_HIGH) begin : gEncHigh
    always_comb begin
      encIdx = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (mask[i]) encIdx = BW'(i);
      end
    end
  end else begin : gEncLow
    always_comb begin
      encIdx = '0;
      for (int unsigned i = WIDTH; i > 0; i--) begin
        if (mask[i-1]) encIdx = BW'(i - 1);
      end
    end
  end

  always_comb begin
    clrMask         = mask;
    clrMask[encIdx] = 1'b0;
    clrLast         = (clrMask == '0);
  end

  // Next-state and register-input logic; abort overrides everything but rst.
  always_comb begin
    stateNxt    = state;
    maskNxt     = mask;
    outBinNxt   = outBin;
    outLastNxt  = outLast;
    outValidNxt = outValid;
    emptyNxt    = 1'b0;

    if (bus.abort) begin
      if (state != IDLE) begin
        maskNxt     = '0;
        outValidNxt = 1'b0;
        outLastNxt  = 1'b0;
        stateNxt    = IDLE;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            maskNxt = bus.in_vec;
            if (bus.in_vec == '0) emptyNxt = 1'b1;
            else                  stateNxt = LOAD;
          end
        end
        LOAD: begin
          outBinNxt   = encIdx;
          outValidNxt = 1'b1;
          maskNxt     = clrMask;
          outLastNxt  = clrLast;
          stateNxt    = EMIT;
        end
        EMIT: begin
          if (outValid && bus.out_ready) begin
            if (outLast) begin
              outValidNxt = 1'b0;
              outLastNxt  = 1'b0;
              stateNxt    = IDLE;
            end else begin
              outBinNxt  = encIdx;
              maskNxt    = clrMask;
              outLastNxt = clrLast;
            end
          end
        end
        default: stateNxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      mask     <= '0;
      outBin   <= '0;
      outLast  <= 1'b0;
      outValid <= 1'b0;
      empty    <= 1'b0;
    end else begin
      state    <= stateNxt;
      mask     <= maskNxt;
      outBin   <= outBinNxt;
      outLast  <= outLastNxt;
      outValid <= outValidNxt;
      empty    <= emptyNxt;
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.out_bin   = outBin;
  assign bus.out_last  = outLast;
  assign bus.out_valid = outValid;
  assign bus.empty     = empty;

endmodule

// File: tb/tb_pe_scan.sv
// Directed bench for pe_scan: two 16-bit instances (low/high priority) share
// stimulus; a 1024-bit instance covers the wide boundary case.
module tb_pe_scan;

  logic clk;
  logic rst;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  pe_scan_if #(.WIDTH(16))   ifLo ();
  pe_scan_if #(.WIDTH(16))   ifHi ();
  pe_scan_if #(.WIDTH(1024)) ifW  ();

  logic [15:0]   vec16;
  logic          valid16, abort16, ready16;
  logic [1023:0] vecW;
  logic          validW, abortW, readyW;

  assign ifLo.in_vec = vec16;  assign ifLo.in_valid = valid16;
  assign ifLo.abort  = abort16; assign ifLo.out_ready = ready16;
  assign ifHi.in_vec = vec16;  assign ifHi.in_valid = valid16;
  assign ifHi.abort  = abort16; assign ifHi.out_ready = ready16;
  assign ifW.in_vec  = vecW;   assign ifW.in_valid  = validW;
  assign ifW.abort   = abortW;  assign ifW.out_ready  = readyW;

  pe_scan #(.WIDTH(16),   .BW(4),  .PRIO_HIGH(1'b0)) uLo (.clk(clk), .rst(rst), .bus(ifLo));
  pe_scan #(.WIDTH(16),   .BW(4),  .PRIO_HIGH(1'b1)) uHi (.clk(clk), .rst(rst), .bus(ifHi));
  pe_scan #(.WIDTH(1024), .BW(10), .PRIO_HIGH(1'b0)) uW  (.clk(clk), .rst(rst), .bus(ifW));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One vector through both 16-bit instances with no backpressure.
  // lo/hi hold the expected index sequences, one nibble per index, first in [3:0].
  task automatic runVec(input logic [15:0] v, input int cnt,
                        input logic [63:0] lo, input logic [63:0] hi);
    @(negedge clk);
    vec16 = v; valid16 = 1'b1;
    chk("accept_ready_lo", 32'(ifLo.in_ready), 32'd1);
    @(negedge clk);
    valid16 = 1'b0;
    chk("load_busy", 32'(ifLo.busy), 32'd1);
    chk("load_no_valid", 32'(ifLo.out_valid), 32'd0);
    for (int k = 0; k < cnt; k++) begin
      @(negedge clk);
      chk("emit_valid_lo", 32'(ifLo.out_valid), 32'd1);
      chk("emit_valid_hi", 32'(ifHi.out_valid), 32'd1);
      chk("bin_lo", 32'(ifLo.out_bin), 32'(lo[4*k +: 4]));
      chk("bin_hi", 32'(ifHi.out_bin), 32'(hi[4*k +: 4]));
      chk("last_lo", 32'(ifLo.out_last), 32'(k == cnt - 1));
      chk("last_hi", 32'(ifHi.out_last), 32'(k == cnt - 1));
    end
    @(negedge clk);
    chk("done_ready_lo", 32'(ifLo.in_ready), 32'd1);
    chk("done_ready_hi", 32'(ifHi.in_ready), 32'd1);
    chk("done_no_valid", 32'(ifLo.out_valid), 32'd0);
  endtask

  typedef struct {
    logic [15:0] vec;
    int          cnt;
    logic [63:0] lo;
    logic [63:0] hi;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int nAcc;
    int expLo;
    int expHi;

    tbl[0] = '{vec: 16'h8421, cnt: 4, lo: 64'hFA50, hi: 64'h05AF};
    tbl[1] = '{vec: 16'h0001, cnt: 1, lo: 64'h0,    hi: 64'h0};
    tbl[2] = '{vec: 16'h8000, cnt: 1, lo: 64'hF,    hi: 64'hF};
    tbl[3] = '{vec: 16'h0180, cnt: 2, lo: 64'h87,   hi: 64'h78};
    tbl[4] = '{vec: 16'hF000, cnt: 4, lo: 64'hFEDC, hi: 64'hCDEF};
    tbl[5] = '{vec: 16'h0006, cnt: 2, lo: 64'h21,   hi: 64'h12};

    rst = 1'b1;
    vec16 = '0; valid16 = 1'b0; abort16 = 1'b0; ready16 = 1'b1;
    vecW = '0;  validW = 1'b0;  abortW = 1'b0;  readyW = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(ifLo.out_valid), 32'd0);
    chk("rst_bin", 32'(ifLo.out_bin), 32'd0);
    chk("rst_last", 32'(ifHi.out_last), 32'd0);
    chk("rst_empty", 32'(ifLo.empty), 32'd0);
    chk("rst_busy", 32'(ifHi.busy), 32'd0);
    chk("rst_ready", 32'(ifW.in_ready), 32'd1);
    rst = 1'b0;

    foreach (tbl[i]) runVec(tbl[i].vec, tbl[i].cnt, tbl[i].lo, tbl[i].hi);

    // Zero vector: one-cycle empty pulse, then a vector is taken right away.
    @(negedge clk);
    vec16 = 16'h0000; valid16 = 1'b1;
    @(negedge clk);
    chk("empty_pulse_lo", 32'(ifLo.empty), 32'd1);
    chk("empty_pulse_hi", 32'(ifHi.empty), 32'd1);
    chk("empty_no_valid", 32'(ifLo.out_valid), 32'd0);
    chk("empty_ready", 32'(ifLo.in_ready), 32'd1);
    vec16 = 16'h0001;
    @(negedge clk);
    valid16 = 1'b0;
    chk("empty_cleared", 32'(ifLo.empty), 32'd0);
    chk("empty_next_busy", 32'(ifLo.busy), 32'd1);
    @(negedge clk);
    chk("empty_next_bin", 32'(ifLo.out_bin), 32'd0);
    chk("empty_next_last", 32'(ifLo.out_last), 32'd1);
    @(negedge clk);

    // Abort in IDLE blocks acceptance.
    vec16 = 16'h00F0; valid16 = 1'b1; abort16 = 1'b1;
    @(negedge clk);
    valid16 = 1'b0; abort16 = 1'b0;
    chk("idle_abort_busy", 32'(ifLo.busy), 32'd0);
    chk("idle_abort_empty", 32'(ifLo.empty), 32'd0);
    @(negedge clk);
    chk("idle_abort_no_valid", 32'(ifLo.out_valid), 32'd0);

    // Backpressure: out_ready alternates, every index held until taken.
    vec16 = 16'hFFFF; valid16 = 1'b1;
    @(negedge clk);
    valid16 = 1'b0;
    nAcc = 0; expLo = 0; expHi = 15;
    for (int cyc = 0; cyc < 80 && nAcc < 16; cyc++) begin
      @(negedge clk);
      ready16 = cyc[0];
      chk("bp_valid", 32'(ifLo.out_valid), 32'd1);
      chk("bp_bin_lo", 32'(ifLo.out_bin), 32'(expLo));
      chk("bp_bin_hi", 32'(ifHi.out_bin), 32'(expHi));
      chk("bp_last", 32'(ifLo.out_last), 32'(expLo == 15));
      if (ready16) begin
        nAcc++; expLo++; expHi--;
      end
    end
    chk("bp_count", 32'(nAcc), 32'd16);
    @(negedge clk);
    ready16 = 1'b1;
    chk("bp_done_ready", 32'(ifLo.in_ready), 32'd1);

    // Abort while index 5 is offered with out_ready high.
    vec16 = 16'h8421; valid16 = 1'b1;
    @(negedge clk);
    valid16 = 1'b0;
    @(negedge clk);
    chk("abort_pre_bin", 32'(ifLo.out_bin), 32'd0);
    @(negedge clk);
    chk("abort_at_bin", 32'(ifLo.out_bin), 32'd5);
    abort16 = 1'b1;
    @(negedge clk);
    abort16 = 1'b0;
    chk("abort_no_valid", 32'(ifLo.out_valid), 32'd0);
    chk("abort_busy_lo", 32'(ifLo.busy), 32'd0);
    chk("abort_busy_hi", 32'(ifHi.busy), 32'd0);
    chk("abort_last", 32'(ifLo.out_last), 32'd0);
    runVec(16'h0002, 1, 64'h1, 64'h1);

    // Asynchronous reset mid-EMIT, observed between clock edges.
    @(negedge clk);
    vec16 = 16'hFFFF; valid16 = 1'b1;
    @(negedge clk);
    valid16 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_valid", 32'(ifLo.out_valid), 32'd1);
    chk("pre_rst_bin", 32'(ifLo.out_bin), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(ifLo.out_valid), 32'd0);
    chk("arst_bin_hi", 32'(ifHi.out_bin), 32'd0);
    chk("arst_last", 32'(ifLo.out_last), 32'd0);
    chk("arst_busy", 32'(ifLo.busy), 32'd0);
    chk("arst_ready", 32'(ifHi.in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Wide instance: only the top bit, then bits 3 and 1023.
    @(negedge clk);
    vecW = '0; vecW[1023] = 1'b1; validW = 1'b1;
    @(negedge clk);
    validW = 1'b0;
    @(negedge clk);
    chk("w_valid", 32'(ifW.out_valid), 32'd1);
    chk("w_bin", 32'(ifW.out_bin), 32'd1023);
    chk("w_last", 32'(ifW.out_last), 32'd1);
    @(negedge clk);
    chk("w_done", 32'(ifW.out_valid), 32'd0);
    vecW[3] = 1'b1; validW = 1'b1;
    @(negedge clk);
    validW = 1'b0;
    @(negedge clk);
    chk("w2_bin0", 32'(ifW.out_bin), 32'd3);
    chk("w2_last0", 32'(ifW.out_last), 32'd0);
    @(negedge clk);
    chk("w2_bin1", 32'(ifW.out_bin), 32'd1023);
    chk("w2_last1", 32'(ifW.out_last), 32'd1);
    @(negedge clk);
    chk("w2_ready", 32'(ifW.in_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
